// File: rtl/sample_stream_fifo.sv
// sample_stream_fifo
//   Parametrised ready/valid stream buffer. Stores up to DEPTH words and
//   replays them in order under backpressure. The data output is registered,
//   and an empty buffer passes a pushed word straight to the head register.
//   Occupancy and wrap-around transfer counters are exposed for inspection.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   stream_in_*         producer side (valid/ready/data), ready registered
//   stream_out_*        consumer side (valid/ready/data), valid+data registered
//   flush               synchronous discard of all stored words
//   level               number of stored words
//   count_in/count_out  accepted input / completed output transfers (wrap)
module sample_stream_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stream_in_valid,
  output logic                       stream_in_ready,
  input  logic [DATA_WIDTH-1:0]      stream_in_data,
  output logic                       stream_out_valid,
  input  logic                       stream_out_ready,
  output logic [DATA_WIDTH-1:0]      stream_out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [COUNT_WIDTH-1:0]     count_in,
  output logic [COUNT_WIDTH-1:0]     count_out
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IN_RESET = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2
  } rst_state_e;

  rst_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          rd_next;
  logic [LW-1:0]          level_q, level_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] count_in_q, count_in_d;
  logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
  logic                   push, pop;

  always_comb begin
    push        = stream_in_valid && in_ready_q && !flush && (state_q != IN_RESET);
    pop         = out_valid_q && stream_out_ready && !flush;
    rd_next     = rd_ptr_q + PW'(1);

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;

    unique case (state_q)
      IN_RESET: state_d = RELEASE;
      RELEASE:  state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = IN_RESET;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_next;
      level_d     = level_q + LW'(push) - LW'(pop);
      count_in_d  = count_in_q + COUNT_WIDTH'(push);
      count_out_d = count_out_q + COUNT_WIDTH'(pop);
      // Head register update. A pushed word becomes the head when the buffer
      // was empty, or when the single stored word leaves in the same cycle
      // (the write slot then equals rd_next but is not yet written).
      if (level_d != '0) begin
        if (level_q == '0)
          out_data_d = stream_in_data;
        else if (pop && level_q == LW'(1))
          out_data_d = stream_in_data;
        else if (pop)
          out_data_d = mem_q[rd_next];
      end
    end

    in_ready_d  = (level_d != LW'(DEPTH));
    out_valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IN_RESET;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_in_q  <= '0;
      count_out_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
    end
  end

  // Storage has no reset; contents are only meaningful below level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stream_in_data;
  end

  assign stream_in_ready  = in_ready_q;
  assign stream_out_valid = out_valid_q;
  assign stream_out_data  = out_data_q;
  assign level            = level_q;
  assign count_in         = count_in_q;
  assign count_out        = count_out_q;

endmodule

// File: doc/sample_stream_fifo.md
# sample_stream_fifo

Parametrised ready/valid stream buffer for the simulator-regression test designs, succeeding the fixed 8-bit, unbuffered stream path of the sample module. It accepts words on an input stream, stores up to DEPTH of them, and replays them in order on an output stream under backpressure. It also exposes occupancy and wrap-around transfer counters for testbench inspection. Test benches drive both sides directly and check handshake, ordering, backpressure and flush behaviour.

## Interface
- DATA_WIDTH, 8: width of stream words; legal range 1..128.
- DEPTH, 4: storage entries; power of two, at least 2.
- COUNT_WIDTH, 16: width of the transfer counters.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high; internal state clears on assertion.
- stream_in_valid  in  1  producer has a word on stream_in_data.
- stream_in_ready  out  1  block can accept a word this cycle; registered.
- stream_in_data  in  DATA_WIDTH  input word.
- stream_out_valid  out  1  stream_out_data holds the oldest stored word; registered.
- stream_out_ready  in  1  consumer accepts the word this cycle.
- stream_out_data  out  DATA_WIDTH  head word; registered.
- flush  in  1  synchronous discard of all stored words.
- level  out  $clog2(DEPTH+1)  number of stored words.
- count_in  out  COUNT_WIDTH  accepted input transfers, modulo 2^COUNT_WIDTH.
- count_out  out  COUNT_WIDTH  completed output transfers, modulo 2^COUNT_WIDTH.

## Operation
- Push: a transfer occurs in a cycle where stream_in_valid && stream_in_ready. The word is written at the write pointer, which then advances modulo DEPTH.
- Pop: a transfer occurs in a cycle where stream_out_valid && stream_out_ready. The read pointer advances modulo DEPTH.
- level_next = level + push − pop. Push and pop may occur in the same cycle; level is then unchanged.
- stream_in_ready_next = (level_next < DEPTH) && !flush_next_cycle_effect.
  - In practice this is (level_next != DEPTH).
  - stream_in_ready does not depend combinationally on stream_out_ready. When full, a same-cycle pop does not allow a same-cycle push.
- stream_out_valid_next = (level_next != 0).
- stream_out_data_next is the word at the next head:
  - Normally it is the stored word at the next read position.
  - When level is 0 and a push occurs, it is the pushed word (fall-through).
  - When level_next becomes 0, stream_out_data holds its last value.
- Flush (flush=1 at an edge):
  - Pointers and level go to 0; stream_out_valid goes to 0; stream_in_ready goes to 1.
  - Any push or pop in the same cycle is ignored, and neither counter increments.
  - count_in and count_out are not cleared by flush.
- Counters:
  - count_in increments on each push; count_out increments on each pop.
  - Both wrap from 2^COUNT_WIDTH−1 to 0 without a flag.
- Ordering: output order equals input order. No word is duplicated or dropped except by flush or reset.
- Reset state machine (reset FSM):
  - States: IN_RESET (rst asserted), RELEASE (first edge after rst deasserts), RUN.
  - IN_RESET → RELEASE on rst deassertion; RELEASE → RUN unconditionally on the next edge. RUN → IN_RESET on any rst assertion.
  - stream_in_ready is 0 in IN_RESET and rises at the RELEASE edge.
  - No push is accepted before stream_in_ready is 1.

## Timing
- Reset values, applied immediately on rst assertion:
  - stream_in_ready=0, stream_out_valid=0, stream_out_data=0.
  - level=0, count_in=0, count_out=0.
  - Pointers are 0; storage contents are undefined.
- First edge after rst falls: stream_in_ready=1, with all other outputs still at their reset values.
- Latency: a word pushed at edge N into an empty buffer has stream_out_valid=1 and the data visible after edge N. It can be popped at edge N+1.
- Throughput: one push and one pop per cycle sustained while 0 < level < DEPTH.
- Full boundary: after the push that makes level=DEPTH, stream_in_ready=0 after that edge. It returns to 1 one edge after the first pop.
- Empty boundary: after the pop that makes level=0 with no simultaneous push, stream_out_valid=0 after that edge.
- Reset mid-operation: all stored words are lost, and both counters read 0 immediately.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. This is transparent at the ports.

## Test plan
- Reset then idle (DATA_WIDTH=8, DEPTH=4):
  - During rst, stream_in_ready=0 and stream_out_valid=0.
  - One edge after release, stream_in_ready=1; level=0, counters 0.
- Fill without popping (stream_out_ready=0), offering 0x11,0x22,0x33,0x44,0x55:
  - The first four are accepted and level=4.
  - stream_in_ready=0 after the 4th push; 0x55 is held by the producer.
  - stream_out_data=0x11 throughout.
- Drain with stream_out_ready=1:
  - Outputs appear in order 0x11,0x22,0x33,0x44, one per cycle.
  - 0x55 is accepted one edge after the first pop.
  - Final state: count_in=5, count_out=5, level=0, stream_out_valid=0.
- Simultaneous push/pop at level 2 for 10 cycles with an incrementing pattern:
  - level stays 2 throughout.
  - count_in−count_out stays 2; data order is preserved.
- Flush at level 3 with stream_in_valid=1 and stream_out_ready=1 in the same cycle:
  - Next cycle level=0, stream_out_valid=0, stream_in_ready=1.
  - Counters are unchanged by that cycle.
- Counter wrap (COUNT_WIDTH=4) with 17 single-word push/pop pairs:
  - count_in=1 and count_out=1.
  - Asserting rst mid-stream clears both counters to 0 immediately.
